control_afisaj: RTL

- Time-multiplexed scan controller for a multi-digit common-anode seven-segment display.
- Shares one BCD-to-seven-segment decoder instance across NR_CIFRE digits.
- Sequences digit select (anodes) and segments, suppresses leading zeros, and inserts a dead-time against ghosting.
- Accepts new display values through a load/ready handshake, applied only at frame boundaries so a frame is never torn.

---
 rtl/afisaj_pkg.sv | 32 +++
 rtl/control_afisaj_generator_tick.sv | 47 ++++
 rtl/decodor_7seg.sv | 32 +++
 rtl/control_afisaj.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/afisaj_pkg.sv
// afisaj_pkg
// Shared definitions for the seven-segment scan controller:
//   - active-low segment patterns, ordered {g,f,e,d,c,b,a}
//   - scan controller state encoding
//   - helper giving the digit index width for a given number of digits
package afisaj_pkg;

  localparam logic [6:0] CIFRA_0   = 7'b1000000;
  localparam logic [6:0] CIFRA_1   = 7'b1111001;
  localparam logic [6:0] CIFRA_2   = 7'b0100100;
  localparam logic [6:0] CIFRA_3   = 7'b0110000;
  localparam logic [6:0] CIFRA_4   = 7'b0011001;
  localparam logic [6:0] CIFRA_5   = 7'b0010010;
  localparam logic [6:0] CIFRA_6   = 7'b0000010;
  localparam logic [6:0] CIFRA_7   = 7'b1111000;
  localparam logic [6:0] CIFRA_8   = 7'b0000000;
  localparam logic [6:0] CIFRA_9   = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_STINS = 7'h7F;

  // OPRIT: display dark, waiting for the first value; SCANARE: scanning.
  typedef enum logic {
    OPRIT   = 1'b0,
    SCANARE = 1'b1
  } stare_t;

  // Width of the digit index; never less than one bit.
  function automatic int latimeCifra(input int nrCifre);
    return (nrCifre > 1) ? $clog2(nrCifre) : 1;
  endfunction

endpackage

// File: rtl/control_afisaj_generator_tick.sv
// generator_tick
// Dwell prescaler for the display scan. Counts 0..DIV_REFRESH-1 while
// enabled and is held at 0 while disabled, so scanning always restarts
// from the beginning of a dwell.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   en_i         - count enable
//   tick_o       - high on the last cycle of a dwell
//   garda_o      - high during the dead-time at the start of a dwell
module generator_tick #(
  parameter int DIV_REFRESH = 50000,
  parameter int GARDA       = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o,
  output logic garda_o
);

  localparam int LC = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;

  logic [LC-1:0] contor_q, contor_d;

  assign tick_o  = en_i && (contor_q == LC'(DIV_REFRESH - 1));
  assign garda_o = (contor_q < LC'(GARDA));

  // Next count: wrap after the last dwell cycle, park at zero when disabled.
  always_comb begin
    contor_d = contor_q;
    if (!en_i || tick_o) begin
      contor_d = '0;
    end else begin
      contor_d = contor_q + LC'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      contor_q <= '0;
    end else begin
      contor_q <= contor_d;
    end
  end

endmodule

// File: rtl/decodor_7seg.sv
// decodor_7seg
// BCD to seven-segment decoder for common-anode displays (active-low).
// Values 10..15 are not BCD and are shown as 'E'.
// Ports:
//   bcd_i  - 4-bit input value
//   seg_o  - segments {g,f,e,d,c,b,a}, active-low
module decodor_7seg
  import afisaj_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup; anything outside 0..9 falls through to the error glyph.
  always_comb begin
    seg_o = SEG_E;
    case (bcd_i)
      4'd0:    seg_o = CIFRA_0;
      4'd1:    seg_o = CIFRA_1;
      4'd2:    seg_o = CIFRA_2;
      4'd3:    seg_o = CIFRA_3;
      4'd4:    seg_o = CIFRA_4;
      4'd5:    seg_o = CIFRA_5;
      4'd6:    seg_o = CIFRA_6;
      4'd7:    seg_o = CIFRA_7;
      4'd8:    seg_o = CIFRA_8;
      4'd9:    seg_o = CIFRA_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/control_afisaj.sv
// control_afisaj
// Time-multiplexed scan controller for a common-anode multi-digit
// seven-segment display, sharing a single decoder across all digits.
// New values are accepted through a load/ready handshake and only take
// effect at a frame boundary, so a frame is never shown half old, half new.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   date_i       - BCD value, nibble 0 is the rightmost digit
//   incarca_i    - load strobe, date_i sampled whenever high
//   gata_o       - high when no update is pending
//   anod_o       - digit enables, active-low, at most one low
//   segmente_o   - segments {g,f,e,d,c,b,a}, active-low
//   cifra_o      - index of the digit being scanned
//   cadru_o      - one-cycle pulse on every frame wrap
module control_afisaj
  import afisaj_pkg::*;
#(
  parameter int NR_CIFRE     = 4,
  parameter int DIV_REFRESH  = 50000,
  parameter int GARDA        = 2,
  parameter bit SUPRIMA_ZERO = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [4*NR_CIFRE-1:0]            date_i,
  input  logic                             incarca_i,
  output logic                             gata_o,
  output logic [NR_CIFRE-1:0]              anod_o,
  output logic [6:0]                       segmente_o,
  output logic [latimeCifra(NR_CIFRE)-1:0] cifra_o,
  output logic                             cadru_o
);

  localparam int            LC     = latimeCifra(NR_CIFRE);
  localparam logic [LC-1:0] ULTIMA = LC'(NR_CIFRE - 1);

  stare_t                stare_q, stare_d;
  logic [LC-1:0]         cifra_q, cifra_d;
  logic [4*NR_CIFRE-1:0] afisaj_q, afisaj_d;
  logic [4*NR_CIFRE-1:0] asteptare_q, asteptare_d;
  logic                  areAsteptare_q, areAsteptare_d;
  logic                  cadru_q, cadru_d;
  logic [NR_CIFRE-1:0]   anod_q, anod_d;
  logic [6:0]            seg_q, seg_d;

  logic                  tick;
  logic                  garda;
  logic                  comit;
  logic [3:0]            nibble;
  logic                  stins;
  logic [NR_CIFRE-1:0]   zeroSus;
  logic [6:0]            segDecodat;

  generator_tick #(
    .DIV_REFRESH(DIV_REFRESH),
    .GARDA      (GARDA)
  ) uGeneratorTick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (stare_q == SCANARE),
    .tick_o (tick),
    .garda_o(garda)
  );

  decodor_7seg uDecodor (
    .bcd_i(nibble),
    .seg_o(segDecodat)
  );

  // A frame ends on the tick that leaves the last digit.
  assign comit = (stare_q == SCANARE) && tick && (cifra_q == ULTIMA);

  // Control path: first load turns the display on directly; afterwards
  // loads are parked in the pending register (last one wins) and moved
  // to the display only at the frame wrap. A load landing exactly on the
  // wrap bypasses the pending register.
  always_comb begin
    stare_d        = stare_q;
    cifra_d        = cifra_q;
    afisaj_d       = afisaj_q;
    asteptare_d    = asteptare_q;
    areAsteptare_d = areAsteptare_q;
    cadru_d        = 1'b0;
    case (stare_q)
      OPRIT: begin
        if (incarca_i) begin
          stare_d  = SCANARE;
          afisaj_d = date_i;
        end
      end
      SCANARE: begin
        if (tick) begin
          cifra_d = (cifra_q == ULTIMA) ? '0 : cifra_q + LC'(1);
        end
        if (comit) begin
          cadru_d        = 1'b1;
          areAsteptare_d = 1'b0;
          asteptare_d    = '0;
          if (incarca_i) begin
            afisaj_d = date_i;
          end else if (areAsteptare_q) begin
            afisaj_d = asteptare_q;
          end
        end else if (incarca_i) begin
          asteptare_d    = date_i;
          areAsteptare_d = 1'b1;
        end
      end
      default: stare_d = OPRIT;
    endcase
  end

  // Digit selection: pick the nibble under scan and decide whether it is
  // a leading zero. zeroSus[i] means nibble i and every higher one are 0.
  always_comb begin
    zeroSus = '0;
    nibble  = '0;
    stins   = 1'b0;
    zeroSus[NR_CIFRE-1] = (afisaj_q[4*NR_CIFRE-1 -: 4] == 4'd0);
    for (int i = NR_CIFRE - 2; i >= 0; i--) begin
      zeroSus[i] = (afisaj_q[4*i +: 4] == 4'd0) && zeroSus[i+1];
    end
    for (int i = 0; i < NR_CIFRE; i++) begin
      if (cifra_q == LC'(i)) begin
        nibble = afisaj_q[4*i +: 4];
        stins  = SUPRIMA_ZERO && (i != 0) && zeroSus[i];
      end
    end
  end

  // Drive pattern for the next cycle: dark while off or in dead-time,
  // otherwise enable the scanned digit and show it unless suppressed.
  always_comb begin
    anod_d = '1;
    seg_d  = SEG_STINS;
    if ((stare_q == SCANARE) && !garda) begin
      for (int i = 0; i < NR_CIFRE; i++) begin
        anod_d[i] = (cifra_q != LC'(i));
      end
      if (!stins) begin
        seg_d = segDecodat;
      end
    end
  end

  // State and output registers; reset discards any pending value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stare_q        <= OPRIT;
      cifra_q        <= '0;
      afisaj_q       <= '0;
      asteptare_q    <= '0;
      areAsteptare_q <= 1'b0;
      cadru_q        <= 1'b0;
      anod_q         <= '1;
      seg_q          <= SEG_STINS;
    end else begin
      stare_q        <= stare_d;
      cifra_q        <= cifra_d;
      afisaj_q       <= afisaj_d;
      asteptare_q    <= asteptare_d;
      areAsteptare_q <= areAsteptare_d;
      cadru_q        <= cadru_d;
      anod_q         <= anod_d;
      seg_q          <= seg_d;
    end
  end

  assign gata_o     = !areAsteptare_q;
  assign anod_o     = anod_q;
  assign segmente_o = seg_q;
  assign cifra_o    = cifra_q;
  assign cadru_o    = cadru_q;

endmodule
